// File: rtl/hog_hist_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : hog_hist_pkg
// Purpose : Shared types and constants for the HOG cell-histogram accumulator.
//           Holds the accumulator state encoding, the default bin/pixel
//           counts and the saturating adder used when HOG_HIST_SAT_EN is set.
// Rev     : 1.0  initial release
// ============================================================================
package hog_hist_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_RD    = 3'd1,
        ST_WR    = 3'd2,
        ST_DONE  = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    localparam int C_NBIN_DEFAULT         = 9;
    localparam int C_PIX_PER_CELL_DEFAULT = 64;

    // Adds two unsigned operands and clamps the result to width bits
    // (all-ones on overflow). Operands are expected to be < 2**width.
    function automatic logic [31:0] f_sat_add(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = (33'd1 << width) - 33'd1;
        return (sum > max) ? max[31:0] : sum[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/hog_hist_sat_add.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : hog_hist_sat_add
// Purpose : Combinational bin update adder: accumulator + zero-extended
//           magnitude, formed DATA_W+1 bits wide.
//           HOG_HIST_SAT_EN defined  : result clamps at 2**DATA_W-1.
//           HOG_HIST_SAT_EN undefined: result wraps modulo 2**DATA_W.
// Ports   : i_acc  [DATA_W-1:0]  current bin value (RAM read data)
//           i_mag  [MAG_W-1:0]   sample magnitude
//           o_sum  [DATA_W-1:0]  updated bin value
// Rev     : 1.0  initial release
// ============================================================================
module hog_hist_sat_add
    import hog_hist_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int MAG_W  = 8
) (
    input  logic [DATA_W-1:0] i_acc,
    input  logic [MAG_W-1:0]  i_mag,
    output logic [DATA_W-1:0] o_sum
);

`ifdef HOG_HIST_SAT_EN
    assign o_sum = DATA_W'(f_sat_add(32'(i_acc), 32'(i_mag), DATA_W));
`else
    logic [DATA_W:0] w_sum;

    assign w_sum = {1'b0, i_acc} + (DATA_W+1)'(i_mag);
    // Carry is dropped: the bin wraps.
    assign o_sum = DATA_W'(w_sum);
`endif

endmodule
`default_nettype wire

// File: rtl/hog_hist_accum.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : hog_hist_accum
// Purpose : Builds one HOG cell histogram in an external dual-port bin RAM by
//           read-modify-write over port a (1-cycle registered read), flags
//           completion to the block-normalisation stage, waits for its
//           acknowledge, then zeroes the bins for the next cell.
//           Build option HOG_HIST_SAT_EN: saturating bin update (default wraps).
// Ports   : clk, rst_n                 clock, synchronous active-low reset
//           in_valid/in_ready          sample handshake
//           in_bin, in_mag             orientation bin and gradient magnitude
//           ram_addr/we/wdata, rdata   bin RAM port a
//           cell_done                  1-cycle pulse, histogram complete
//           hist_ack                   downstream finished reading bins
//           bin_err                    1-cycle pulse, sample bin >= NBIN
// Rev     : 1.0  initial release
// ============================================================================
module hog_hist_accum
    import hog_hist_pkg::*;
#(
    parameter int DATA_W       = 12,
    parameter int ADDR_W       = 5,
    parameter int MAG_W        = 8,
    parameter int NBIN         = C_NBIN_DEFAULT,
    parameter int PIX_PER_CELL = C_PIX_PER_CELL_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_bin,
    input  logic [MAG_W-1:0]  in_mag,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              cell_done,
    input  logic              hist_ack,
    output logic              bin_err
);

    localparam int                c_cnt_w     = $clog2(PIX_PER_CELL + 1);
    localparam logic [ADDR_W:0]   c_nbin      = (ADDR_W+1)'(NBIN);
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(NBIN - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(PIX_PER_CELL - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;    // clear pointer in CLEAR, latched bin in WR
    logic [MAG_W-1:0]    r_mag;
    logic                r_bin_ok;  // latched bin is inside the histogram
    logic [c_cnt_w-1:0]  r_cnt;

    logic                w_in_rd;
    logic                w_in_wr;
    logic [DATA_W-1:0]   w_sum;

    hog_hist_sat_add #(
        .DATA_W (DATA_W),
        .MAG_W  (MAG_W)
    ) u_sat_add (
        .i_acc  (ram_rdata),
        .i_mag  (r_mag),
        .o_sum  (w_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_CLEAR;
            r_addr   <= '0;
            r_mag    <= '0;
            r_bin_ok <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_addr == c_last_addr) begin
                        r_state <= ST_RD;
                        r_cnt   <= '0;
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                ST_RD: begin
                    if (in_valid) begin
                        r_addr   <= in_bin;
                        r_mag    <= in_mag;
                        r_bin_ok <= ({1'b0, in_bin} < c_nbin);
                        r_state  <= ST_WR;
                    end
                end
                ST_WR: begin
                    // Out-of-range samples still count toward the cell.
                    r_cnt   <= r_cnt + c_cnt_w'(1);
                    r_state <= (r_cnt == c_cnt_last) ? ST_DONE : ST_RD;
                end
                ST_DONE: begin
                    r_addr  <= '0;
                    r_state <= hist_ack ? ST_CLEAR : ST_WAIT;
                end
                ST_WAIT: begin
                    r_addr <= '0;
                    if (hist_ack) begin
                        r_state <= ST_CLEAR;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_addr  <= '0;
                end
            endcase
        end
    end

    assign w_in_rd = (r_state == ST_RD);
    assign w_in_wr = (r_state == ST_WR);

    // Outputs are decoded from registered state. They are also gated by
    // rst_n so that a write pending when reset arrives never reaches the
    // RAM, and everything reads zero while reset is held.
    // In RD the address comes straight from in_bin so the read data is
    // ready for the update in the following WR cycle.
    assign in_ready  = rst_n & w_in_rd;
    assign ram_addr  = !rst_n ? '0 : (w_in_rd ? in_bin : r_addr);
    assign ram_we    = rst_n & ((r_state == ST_CLEAR) | (w_in_wr & r_bin_ok));
    assign ram_wdata = (rst_n & w_in_wr & r_bin_ok) ? w_sum : '0;
    assign cell_done = rst_n & (r_state == ST_DONE);
    assign bin_err   = rst_n & w_in_wr & ~r_bin_ok;

endmodule
`default_nettype wire

// File: tb/tb_hog_hist_accum.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_hog_hist_accum
// Purpose : Self-checking bench for hog_hist_accum. Instance A uses
//           PIX_PER_CELL=4 for handshake, timing, clear and reset behaviour;
//           instance B uses PIX_PER_CELL=18 to drive one bin to its limit.
//           Each instance has its own bin RAM model with 1-cycle read.
// Rev     : 1.0  initial release
// ============================================================================
module tb_hog_hist_accum;

    localparam int DW = 12;
    localparam int AW = 5;
    localparam int MW = 8;
    localparam int NB = 9;

    typedef struct {
        logic [AW-1:0] bin;
        logic [MW-1:0] mag;
        logic          we;     // expected ram_we in WR
        logic [DW-1:0] wdata;  // expected ram_wdata in WR
        logic          err;    // expected bin_err in WR
        logic          done;   // expected cell_done the cycle after WR
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic          a_ready, b_ready;
    logic [AW-1:0] a_bin = '0, b_bin = '0, a_addr, b_addr;
    logic [MW-1:0] a_mag = '0, b_mag = '0;
    logic          a_we, b_we, a_done, b_done, a_err, b_err;
    logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic          a_ack = 1'b0, b_ack = 1'b0;

    logic [DW-1:0] mem_a [32];
    logic [DW-1:0] mem_b [32];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    vec_t cell1 [4];
    vec_t cell2 [4];
    vec_t pre_rst [2];
    vec_t cell3 [4];
    int   exp1 [9];
    int   exp2 [9];

    hog_hist_accum #(.DATA_W(DW), .ADDR_W(AW), .MAG_W(MW), .NBIN(NB), .PIX_PER_CELL(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
        .in_bin(a_bin), .in_mag(a_mag), .ram_addr(a_addr), .ram_we(a_we),
        .ram_wdata(a_wdata), .ram_rdata(a_rdata), .cell_done(a_done),
        .hist_ack(a_ack), .bin_err(a_err)
    );

    hog_hist_accum #(.DATA_W(DW), .ADDR_W(AW), .MAG_W(MW), .NBIN(NB), .PIX_PER_CELL(18)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
        .in_bin(b_bin), .in_mag(b_mag), .ram_addr(b_addr), .ram_we(b_we),
        .ram_wdata(b_wdata), .ram_rdata(b_rdata), .cell_done(b_done),
        .hist_ack(b_ack), .bin_err(b_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bin RAM models: port a write plus registered read (old data on collision).
    always @(posedge clk) begin
        if (a_we) mem_a[a_addr] <= a_wdata;
        a_rdata <= mem_a[a_addr];
        if (b_we) mem_b[b_addr] <= b_wdata;
        b_rdata <= mem_b[b_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called #1 after a rising edge. Presents one sample, waits (bounded) for
    // acceptance, checks the WR cycle and then cell_done in the next cycle.
    // Returns #1 after the edge that ends WR; in_valid is left asserted.
    task automatic send(input bit sel, input vec_t v);
        int n;
        if (sel) begin b_valid = 1'b1; b_bin = v.bin; b_mag = v.mag; end
        else     begin a_valid = 1'b1; a_bin = v.bin; a_mag = v.mag; end
        n = 0;
        @(negedge clk);
        while (((sel ? b_ready : a_ready) !== 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready low for %0d cycles, expected high", n);
            return;
        end
        check("rd_addr", 32'(sel ? b_addr : a_addr), 32'(v.bin));
        acc_cyc = cyc;
        @(posedge clk); #1;
        @(negedge clk);
        check("wr_in_ready", 32'(sel ? b_ready : a_ready), 32'd0);
        check("wr_we", 32'(sel ? b_we : a_we), 32'(v.we));
        if (v.we) check("wr_wdata", 32'(sel ? b_wdata : a_wdata), 32'(v.wdata));
        check("wr_bin_err", 32'(sel ? b_err : a_err), 32'(v.err));
        @(posedge clk); #1;
        check("cell_done", 32'(sel ? b_done : a_done), 32'(v.done));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_acc;
        int n;
        int acc;
        vec_t v;
        logic [DW-1:0] sat_final;

        for (int i = 0; i < 32; i++) begin mem_a[i] = '0; mem_b[i] = '0; end

        //            bin    mag     we    wdata     err   done
        cell1[0] = '{5'd2,  8'd10,  1'b1, 12'd10,  1'b0, 1'b0};
        cell1[1] = '{5'd2,  8'd20,  1'b1, 12'd30,  1'b0, 1'b0};
        cell1[2] = '{5'd5,  8'd7,   1'b1, 12'd7,   1'b0, 1'b0};
        cell1[3] = '{5'd2,  8'd1,   1'b1, 12'd31,  1'b0, 1'b1};
        cell2[0] = '{5'd12, 8'd50,  1'b0, 12'd0,   1'b1, 1'b0};
        cell2[1] = '{5'd0,  8'd3,   1'b1, 12'd3,   1'b0, 1'b0};
        cell2[2] = '{5'd8,  8'd255, 1'b1, 12'd255, 1'b0, 1'b0};
        cell2[3] = '{5'd0,  8'd4,   1'b1, 12'd7,   1'b0, 1'b1};
        pre_rst[0] = '{5'd1, 8'd5,  1'b1, 12'd5,   1'b0, 1'b0};
        pre_rst[1] = '{5'd1, 8'd6,  1'b1, 12'd11,  1'b0, 1'b0};
        cell3[0] = '{5'd4,  8'd1,   1'b1, 12'd1,   1'b0, 1'b0};
        cell3[1] = '{5'd4,  8'd2,   1'b1, 12'd3,   1'b0, 1'b0};
        cell3[2] = '{5'd4,  8'd3,   1'b1, 12'd6,   1'b0, 1'b0};
        cell3[3] = '{5'd4,  8'd4,   1'b1, 12'd10,  1'b0, 1'b1};
        exp1 = '{0, 0, 31, 0, 0, 7, 0, 0, 0};
        exp2 = '{7, 0, 0, 0, 0, 0, 0, 0, 255};
`ifdef HOG_HIST_SAT_EN
        sat_final = 12'd4095;
`else
        sat_final = 12'd14;
`endif

        // ---- reset and clear sweep ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_flags", 32'({a_ready, a_we, a_done, a_err}), 32'd0);
        check("rst_addr", 32'(a_addr), 32'd0);
        check("rst_wdata", 32'(a_wdata), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            check("clr_we", 32'(a_we), 32'd1);
            check("clr_addr", 32'(a_addr), 32'(k));
            check("clr_wdata", 32'(a_wdata), 32'd0);
            check("clr_ready", 32'(a_ready), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("first_ready_a", 32'(a_ready), 32'd1);
        check("first_ready_b", 32'(b_ready), 32'd1);

        // hist_ack in RD has no effect
        @(posedge clk); #1;
        a_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("ack_in_rd_ready", 32'(a_ready), 32'd1);
            @(posedge clk); #1;
        end
        a_ack = 1'b0;

        // ---- cell 1: back-to-back samples ----
        first_acc = 0;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, cell1[i]);
            if (i == 0) first_acc = acc_cyc;
        end
        a_valid = 1'b0;
        // DONE is the 9th cycle counting the first accept cycle as the 1st.
        check("done_latency", 32'(cyc - first_acc), 32'd8);
        for (int b = 0; b < NB; b++) check("cell1_bin", 32'(mem_a[b]), 32'(exp1[b]));

        // ---- WAIT dwell with hist_ack low ----
        @(posedge clk); #1;
        repeat (20) begin
            @(negedge clk);
            check("wait_idle", 32'({a_ready, a_we, a_done}), 32'd0);
            @(posedge clk); #1;
        end
        a_ack = 1'b1;
        @(negedge clk);
        check("wait_ack_cycle_we", 32'(a_we), 32'd0);
        @(posedge clk); #1;
        a_ack = 1'b0;
        @(negedge clk);
        check("wait_exit_we", 32'(a_we), 32'd1);
        check("wait_exit_addr", 32'(a_addr), 32'd0);
        @(posedge clk); #1;

        // ---- cell 2: out-of-range bin, then ack during DONE ----
        for (int i = 0; i < 4; i++) send(1'b0, cell2[i]);
        a_valid = 1'b0;
        for (int b = 0; b < NB; b++) check("cell2_bin", 32'(mem_a[b]), 32'(exp2[b]));
        check("cell2_oob_untouched", 32'(mem_a[12]), 32'd0);
        a_ack = 1'b1;
        @(posedge clk); #1;
        a_ack = 1'b0;
        @(negedge clk);
        check("skip_wait_we", 32'(a_we), 32'd1);
        check("skip_wait_addr", 32'(a_addr), 32'd0);
        @(posedge clk); #1;

        // ---- reset during WR of the third sample ----
        for (int i = 0; i < 2; i++) send(1'b0, pre_rst[i]);
        a_bin = 5'd1;
        a_mag = 8'd9;
        n = 0;
        @(negedge clk);
        while (a_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("rst_s3_accept_ready", 32'(a_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_in_wr_we", 32'(a_we), 32'd0);
        @(posedge clk); #1;
        a_valid = 1'b0;
        check("rst_dropped_write", 32'(mem_a[1]), 32'd11);
        @(negedge clk);
        check("rst_hold_flags", 32'({a_ready, a_we, a_done, a_err}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_restart_we", 32'(a_we), 32'd1);
        check("rst_restart_addr", 32'(a_addr), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send(1'b0, cell3[i]);
        a_valid = 1'b0;
        check("cell3_bin4", 32'(mem_a[4]), 32'd10);
        check("cell3_bin1_cleared", 32'(mem_a[1]), 32'd0);

        // ---- instance B: drive bin 3 to 4090, then add 20 ----
        acc = 0;
        for (int k = 0; k < 18; k++) begin
            v.bin  = 5'd3;
            v.mag  = (k < 16) ? 8'd255 : ((k == 16) ? 8'd10 : 8'd20);
            acc    = acc + int'(v.mag);
            v.we   = 1'b1;
            v.wdata = (k < 17) ? DW'(acc) : sat_final;
            v.err  = 1'b0;
            v.done = (k == 17);
            send(1'b1, v);
        end
        b_valid = 1'b0;
        check("sat_bin3", 32'(mem_b[3]), 32'(sat_final));

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
